// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
//   Timed select generator for a 1:8 demux stage. It sweeps the 3-bit select
//   s through the channels. Each channel is held for dwell+1 cycles. The order
//   is up, down or ping-pong, and a sweep runs once or loops forever. The data
//   input i is high while a sequence runs.
// Ports:
//   clk, rst        clock (rising edge), async active-high reset
//   start, stop     begin (sampled in IDLE only) / abort the sequence
//   mode            00 up, 01 down, 10 ping-pong, 11 up
//   loop            1 = repeat the pass forever
//   dwell           per-channel hold count (cycles = dwell+1)
//   i, s            demux data input / select (registered)
//   busy            high while running
//   done            1-cycle pulse on normal (non-aborted) completion
//   step            1-cycle pulse whenever s changes inside a run
module demux_sel_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell,
  output logic               i,
  output logic [2:0]         s,
  output logic               busy,
  output logic               done,
  output logic               step
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] M_DOWN = 2'b01;
  localparam logic [1:0] M_PP   = 2'b10;

  state_t             state_q, state_d;
  logic [2:0]         s_q, s_d;
  logic               i_q, i_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               step_q, step_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
  logic [1:0]         mode_l_q, mode_l_d;
  logic               loop_l_q, loop_l_d;
  logic               dir_dn_q, dir_dn_d;   // ping-pong: 1 while descending
  logic               last_slot;

  // The pass ends when the final channel's dwell expires. In ping-pong order
  // that channel is 0, reached on the way back down.
  always_comb begin
    case (mode_l_q)
      M_DOWN:  last_slot = (s_q == 3'd0);
      M_PP:    last_slot = (s_q == 3'd0) && dir_dn_q;
      default: last_slot = (s_q == 3'd7);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    i_d       = i_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    step_d    = 1'b0;
    cnt_d     = cnt_q;
    dwell_l_d = dwell_l_q;
    mode_l_d  = mode_l_q;
    loop_l_d  = loop_l_q;
    dir_dn_d  = dir_dn_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d   = RUN;
          i_d       = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          dwell_l_d = dwell;
          mode_l_d  = mode;
          loop_l_d  = loop;
          dir_dn_d  = 1'b0;
          s_d       = (mode == M_DOWN) ? 3'd7 : 3'd0;
        end
      end
      default: begin
        if (stop) begin
          state_d = IDLE;
          i_d     = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != dwell_l_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (last_slot && !loop_l_q) begin
            state_d = IDLE;
            i_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d = 1'b1;
            // 3-bit arithmetic gives the 7->0 / 0->7 loop wraps for free.
            case (mode_l_q)
              M_DOWN: s_d = s_q - 3'd1;
              M_PP: begin
                if (!dir_dn_q) begin
                  if (s_q == 3'd7) begin
                    s_d      = 3'd6;
                    dir_dn_d = 1'b1;
                  end else begin
                    s_d = s_q + 3'd1;
                  end
                end else if (s_q == 3'd0) begin
                  // Loop wrap: 0 is not repeated.
                  s_d      = 3'd1;
                  dir_dn_d = 1'b0;
                end else begin
                  s_d = s_q - 3'd1;
                end
              end
              default: s_d = s_q + 3'd1;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      i_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= 1'b0;
      cnt_q     <= '0;
      dwell_l_q <= '0;
      mode_l_q  <= '0;
      loop_l_q  <= 1'b0;
      dir_dn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      i_q       <= i_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      dwell_l_q <= dwell_l_d;
      mode_l_q  <= mode_l_d;
      loop_l_q  <= loop_l_d;
      dir_dn_q  <= dir_dn_d;
    end
  end

  assign i    = i_q;
  assign s    = s_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;
endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Testbench for demux_sel_sequencer: table-driven cycle vectors plus
// hand-written reset and long-dwell sequences.
module tb_demux_sel_sequencer;
  logic       clk, rst, start, stop, loop, i, busy, done, step;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic [2:0] s;

  int checks   = 0;
  int failures = 0;

  demux_sel_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .loop(loop), .dwell(dwell), .i(i), .s(s), .busy(busy), .done(done),
    .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       start, stop;
    logic [1:0] mode;
    logic       loop;
    logic [7:0] dwell;
    logic       e_i;
    logic [2:0] e_s;
    logic       e_busy, e_done, e_step;
    string      nm;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic st, input logic sp, input logic [1:0] md,
                     input logic lp, input logic [7:0] dw, input logic ei, input int es,
                     input logic eb, input logic ed, input logic ep);
    vec_t v;
    v.nm = nm; v.start = st; v.stop = sp; v.mode = md; v.loop = lp; v.dwell = dw;
    v.e_i = ei; v.e_s = 3'(es); v.e_busy = eb; v.e_done = ed; v.e_step = ep;
    vq.push_back(v);
  endtask

  // Drive inputs mid-cycle, sample 1 time unit after the next rising edge.
  task automatic cyc(input logic st, input logic sp, input logic [1:0] md,
                     input logic lp, input logic [7:0] dw);
    @(negedge clk);
    start = st; stop = sp; mode = md; loop = lp; dwell = dw;
    @(posedge clk);
    #1;
  endtask

  int pp[15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    int bad, dones;
    rst = 1'b1; start = 0; stop = 0; mode = 0; loop = 0; dwell = 0;
    #2;
    chk("reset_state", {11'd0, i, s, busy, done, step}, 16'd0);

    // T1: up single-shot, dwell=1
    add("up1", 1, 0, 2'b00, 0, 8'd1, 1, 0, 1, 0, 0);
    for (int n = 2; n <= 16; n++) add("up1", 0, 0, 2'b00, 0, 8'd1, 1, (n-1)/2, 1, 0, n % 2);
    add("up1_done", 0, 0, 2'b00, 0, 8'd1, 0, 7, 0, 1, 0);
    add("up1_idle", 0, 0, 2'b00, 0, 8'd1, 0, 7, 0, 0, 0);
    // start+stop together in IDLE
    add("start_stop", 1, 1, 2'b00, 0, 8'd1, 0, 7, 0, 0, 0);
    add("start_stop", 1, 1, 2'b00, 0, 8'd1, 0, 7, 0, 0, 0);
    // T2: down loop, dwell=0, stop while s=3
    add("dn_loop", 1, 0, 2'b01, 1, 8'd0, 1, 7, 1, 0, 0);
    for (int n = 2; n <= 13; n++) add("dn_loop", 0, 0, 2'b01, 1, 8'd0, 1, (16-n) % 8, 1, 0, 1);
    add("dn_stop", 0, 1, 2'b01, 1, 8'd0, 0, 3, 0, 0, 0);
    add("dn_idle", 0, 0, 2'b01, 1, 8'd0, 0, 3, 0, 0, 0);
    // T3: ping-pong single-shot, dwell=0
    add("pp1", 1, 0, 2'b10, 0, 8'd0, 1, 0, 1, 0, 0);
    for (int n = 2; n <= 15; n++) add("pp1", 0, 0, 2'b10, 0, 8'd0, 1, pp[n-1], 1, 0, 1);
    add("pp1_done", 0, 0, 2'b10, 0, 8'd0, 0, 0, 0, 1, 0);
    add("pp1_idle", 0, 0, 2'b10, 0, 8'd0, 0, 0, 0, 0, 0);
    // T3b: ping-pong loop wraps 0->1
    add("pp_loop", 1, 0, 2'b10, 1, 8'd0, 1, 0, 1, 0, 0);
    for (int n = 2; n <= 15; n++) add("pp_loop", 0, 0, 2'b10, 1, 8'd0, 1, pp[n-1], 1, 0, 1);
    add("pp_wrap", 0, 0, 2'b10, 1, 8'd0, 1, 1, 1, 0, 1);
    add("pp_wrap", 0, 0, 2'b10, 1, 8'd0, 1, 2, 1, 0, 1);
    add("pp_stop", 0, 1, 2'b10, 1, 8'd0, 0, 2, 0, 0, 0);
    // T4: up dwell=3; mid-run start pulse and dwell/mode changes are ignored
    add("up3", 1, 0, 2'b00, 0, 8'd3, 1, 0, 1, 0, 0);
    for (int n = 2; n <= 32; n++)
      add("up3_ignore", (n == 6), 0, (n >= 6) ? 2'b01 : 2'b00, 0, (n >= 6) ? 8'd0 : 8'd3,
          1, (n-1)/4, 1, 0, ((n-1) % 4 == 0));
    add("up3_done", 0, 0, 2'b01, 0, 8'd0, 0, 7, 0, 1, 0);
    add("up3_idle", 0, 0, 2'b01, 0, 8'd0, 0, 7, 0, 0, 0);

    @(negedge clk) rst = 1'b0;
    foreach (vq[k]) begin
      cyc(vq[k].start, vq[k].stop, vq[k].mode, vq[k].loop, vq[k].dwell);
      chk($sformatf("%s[%0d]", vq[k].nm, k), {11'd0, i, s, busy, done, step},
          {11'd0, vq[k].e_i, vq[k].e_s, vq[k].e_busy, vq[k].e_done, vq[k].e_step});
    end

    // T5: async reset mid-run (up, dwell=2) while s=4
    cyc(1, 0, 2'b00, 0, 8'd2);
    for (int n = 2; n <= 14; n++) cyc(0, 0, 2'b00, 0, 8'd2);
    chk("rst_pre_s", {13'd0, s}, 16'd4);
    #3 rst = 1'b1;
    #1 chk("rst_async", {11'd0, i, s, busy, done, step}, 16'd0);
    @(negedge clk) rst = 1'b0;
    cyc(1, 0, 2'b00, 0, 8'd2);
    chk("rst_restart", {11'd0, i, s, busy, done, step}, {11'd0, 1'b1, 3'd0, 1'b1, 2'b00});
    cyc(0, 0, 2'b00, 0, 8'd2);
    cyc(0, 0, 2'b00, 0, 8'd2);
    cyc(0, 0, 2'b00, 0, 8'd2);
    chk("rst_restart_step", {11'd0, i, s, busy, done, step}, {11'd0, 1'b1, 3'd1, 1'b1, 2'b01});
    for (int n = 5; n <= 25; n++) cyc(0, 0, 2'b00, 0, 8'd2);
    chk("rst_restart_done", {11'd0, i, s, busy, done, step}, {11'd0, 1'b0, 3'd7, 1'b0, 2'b10});

    // T6: dwell=255, up single-shot: 256 cycles per channel, 2048 total
    bad = 0; dones = 0;
    cyc(1, 0, 2'b00, 0, 8'd255);
    for (int n = 1; n <= 2048; n++) begin
      if (n > 1) cyc(0, 0, 2'b00, 0, 8'd255);
      if (i !== 1'b1 || s !== 3'((n-1)/256) || step !== ((n > 1) && ((n-1) % 256 == 0))) bad++;
      if (done) dones++;
    end
    chk("dw255_hold_errs", 16'(bad), 16'd0);
    cyc(0, 0, 2'b00, 0, 8'd255);
    chk("dw255_end", {11'd0, i, s, busy, done, step}, {11'd0, 1'b0, 3'd7, 1'b0, 2'b10});
    if (done) dones++;
    cyc(0, 0, 2'b00, 0, 8'd255);
    if (done) dones++;
    chk("dw255_done_count", 16'(dones), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
